// File: rtl/gaussian_pkg.sv
// Shared constants and helpers for the CDT discrete-Gaussian sampler:
// Tausworthe recurrences, seed limits, channel offset and the sigma = 3.19 threshold table.
package gaussian_pkg;

  localparam int CDT_MAX = 16;

  // One part in 1e8 of the 2^63 probability scale.
  localparam logic [63:0] CDT_UNIT   = 64'd92233720368;
  localparam logic [63:0] GOLDEN_OFS = 64'h9E3779B97F4A7C15;

  localparam logic [63:0] Z1_MIN = 64'd2;
  localparam logic [63:0] Z2_MIN = 64'd512;
  localparam logic [63:0] Z3_MIN = 64'd4096;

  localparam int unsigned T1_Q = 1,  T1_S = 53, T1_R = 10;
  localparam int unsigned T2_Q = 24, T2_S = 50, T2_R = 5;
  localparam int unsigned T3_Q = 3,  T3_S = 23, T3_R = 29;
  localparam logic [63:0] T1_M = ~64'd1;
  localparam logic [63:0] T2_M = ~64'd511;
  localparam logic [63:0] T3_M = ~64'd4095;

  typedef struct packed {
    logic [63:0] z3;
    logic [63:0] z2;
    logic [63:0] z1;
  } taus_state_t;

  function automatic logic [63:0] taus_comp(input logic [63:0] z, input int unsigned q,
                                            input int unsigned s, input int unsigned r,
                                            input logic [63:0] m);
    logic [63:0] b;
    b = ((z << q) ^ z) >> s;
    return ((z & m) << r) ^ b;
  endfunction

  function automatic taus_state_t taus_step(input taus_state_t st);
    taus_state_t nx;
    nx.z1 = taus_comp(st.z1, T1_Q, T1_S, T1_R, T1_M);
    nx.z2 = taus_comp(st.z2, T2_Q, T2_S, T2_R, T2_M);
    nx.z3 = taus_comp(st.z3, T3_Q, T3_S, T3_R, T3_M);
    return nx;
  endfunction

  function automatic logic [63:0] chan_init(input logic [63:0] base, input int c);
    return base ^ ((64'(c) * GOLDEN_OFS) << 16);
  endfunction

  // Entry i is P(|x| <= i) of the folded distribution, scaled to 2^63.
  function automatic logic [62:0] cdt_threshold(input int i);
    logic [63:0] w_ppb;
    case (i)
      0:       w_ppb = 64'd12505940;
      1:       w_ppb = 64'd36318600;
      2:       w_ppb = 64'd56867600;
      3:       w_ppb = 64'd72941200;
      4:       w_ppb = 64'd84336400;
      5:       w_ppb = 64'd91659300;
      6:       w_ppb = 64'd95924400;
      7:       w_ppb = 64'd98176600;
      8:       w_ppb = 64'd99254200;
      9:       w_ppb = 64'd99721500;
      10:      w_ppb = 64'd99905200;
      11:      w_ppb = 64'd99970700;
      12:      w_ppb = 64'd99991800;
      13:      w_ppb = 64'd99998000;
      14:      w_ppb = 64'd99999510;
      15:      w_ppb = 64'd99999914;
      default: w_ppb = 64'd100000000;
    endcase
    return 63'(w_ppb * CDT_UNIT);
  endfunction

endpackage

// File: rtl/taus_urng.sv
// One channel of combined three-component 64-bit Tausworthe URNG.
// o_u is the registered first pipeline stage: the XOR of the freshly stepped state.
module taus_urng
  import gaussian_pkg::*;
#(
  parameter logic [63:0] INIT_Z1 = 64'd5030521883283424767,
  parameter logic [63:0] INIT_Z2 = 64'd18445829279364155008,
  parameter logic [63:0] INIT_Z3 = 64'd18436106298727503359
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [191:0] i_seed,
  input  logic         i_adv,
  output logic [63:0]  o_u
);

  taus_state_t r_state;
  taus_state_t w_next;
  logic [63:0] r_u;

  assign w_next = taus_step(r_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '{z3: INIT_Z3, z2: INIT_Z2, z1: INIT_Z1};
      r_u     <= '0;
    end else if (i_load) begin
      r_state <= taus_state_t'(i_seed);
    end else if (i_adv) begin
      r_state <= w_next;
      r_u     <= w_next.z1 ^ w_next.z2 ^ w_next.z3;
    end
  end

  assign o_u = r_u;

endmodule

// File: rtl/gaussian_cdt_mc.sv
// Multi-channel constant-time CDT Gaussian sampler: URNG -> threshold count -> signed sample.
// All channels advance in lockstep; a seed load stalls every URNG for that cycle and flushes the pipe.
module gaussian_cdt_mc
  import gaussian_pkg::*;
#(
  parameter int          NCH       = 4,
  parameter int          DW        = 16,
  parameter int          CDT_DEPTH = 16,
  parameter logic [63:0] INIT_Z1   = 64'd5030521883283424767,
  parameter logic [63:0] INIT_Z2   = 64'd18445829279364155008,
  parameter logic [63:0] INIT_Z3   = 64'd18436106298727503359
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ce,
  input  logic                                   seed_valid,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] seed_ch,
  input  logic [191:0]                           seed_data,
  output logic                                   seed_err,
  output logic                                   valid_out,
  input  logic                                   ready_in,
  output logic [NCH*DW-1:0]                      data_out
);

  localparam int MW = $clog2(CDT_DEPTH + 1);

  logic        w_seed_ok;
  logic        w_seed_acc;
  logic        w_adv;
  logic        w_step;
  logic        r_v1, r_v2, r_v3;
  logic        r_seed_err;
  logic [63:0] w_u [NCH];

  assign w_seed_ok  = (int'(seed_ch) < NCH) &&
                      (seed_data[63:0]    >= Z1_MIN) &&
                      (seed_data[127:64]  >= Z2_MIN) &&
                      (seed_data[191:128] >= Z3_MIN);
  assign w_seed_acc = seed_valid & w_seed_ok;
  assign w_adv      = ce & (~r_v3 | ready_in);
  assign w_step     = w_adv & ~w_seed_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_seed_err <= 1'b0;
    end else begin
      r_seed_err <= seed_valid & ~w_seed_ok;
      if (w_seed_acc) begin
        r_v1 <= 1'b0;
        r_v2 <= 1'b0;
        r_v3 <= 1'b0;
      end else if (w_step) begin
        r_v1 <= 1'b1;
        r_v2 <= r_v1;
        r_v3 <= r_v2;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic          w_load;
    logic [MW-1:0] w_mag;
    logic          r_sign;
    logic [MW-1:0] r_mag;
    logic [DW-1:0] r_res;

    assign w_load = w_seed_acc && (int'(seed_ch) == c);

    taus_urng #(
      .INIT_Z1(chan_init(INIT_Z1, c)),
      .INIT_Z2(chan_init(INIT_Z2, c)),
      .INIT_Z3(chan_init(INIT_Z3, c))
    ) u_urng (
      .clk   (clk),
      .rst   (rst),
      .i_load(w_load),
      .i_seed(seed_data),
      .i_adv (w_step),
      .o_u   (w_u[c])
    );

    // Every threshold is compared every cycle so timing does not depend on the sample.
    always_comb begin
      w_mag = '0;
      for (int i = 0; i < CDT_DEPTH; i++) begin
        w_mag = w_mag + MW'(w_u[c][62:0] >= cdt_threshold(i));
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sign <= 1'b0;
        r_mag  <= '0;
        r_res  <= '0;
      end else if (w_step) begin
        r_sign <= w_u[c][63];
        r_mag  <= w_mag;
        r_res  <= (r_sign && (r_mag != '0)) ? -DW'(r_mag) : DW'(r_mag);
      end
    end

    assign data_out[c*DW +: DW] = r_res;
  end

  assign valid_out = r_v3;
  assign seed_err  = r_seed_err;

endmodule

// File: tb/tb_gaussian_cdt_mc.sv
// Scoreboard bench for gaussian_cdt_mc: an independent Tausworthe/CDT model feeds a queue that
// mirrors the three in-flight samples; each clock the DUT outputs are compared against it.
module tb_gaussian_cdt_mc;

  localparam int NCH   = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam logic [63:0] I1  = 64'd5030521883283424767;
  localparam logic [63:0] I2  = 64'd18445829279364155008;
  localparam logic [63:0] I3  = 64'd18436106298727503359;
  localparam logic [63:0] GLD = 64'h9E3779B97F4A7C15;

  logic               clk = 1'b0;
  logic               rst, ce, seed_valid, ready_in;
  logic [1:0]         seed_ch;
  logic [191:0]       seed_data;
  logic               seed_err, valid_out;
  logic [NCH*DW-1:0]  data_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0]       m_z1 [NCH];
  logic [63:0]       m_z2 [NCH];
  logic [63:0]       m_z3 [NCH];
  logic [62:0]       thr  [DEPTH];
  logic [NCH*DW-1:0] sb_q [$];
  logic              exp_err = 1'b0;
  logic [NCH*DW-1:0] pwr_first;

  always #5 clk = ~clk;

  gaussian_cdt_mc #(.NCH(NCH), .DW(DW), .CDT_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .seed_valid(seed_valid),
    .seed_ch   (seed_ch),
    .seed_data (seed_data),
    .seed_err  (seed_err),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .data_out  (data_out)
  );

  task automatic init_table();
    longint unsigned ppb [DEPTH];
    ppb = '{12505940, 36318600, 56867600, 72941200, 84336400, 91659300, 95924400, 98176600,
            99254200, 99721500, 99905200, 99970700, 99991800, 99998000, 99999510, 99999914};
    for (int i = 0; i < DEPTH; i++) thr[i] = 63'(ppb[i] * 64'd92233720368);
  endtask

  task automatic reset_model();
    for (int c = 0; c < NCH; c++) begin
      m_z1[c] = I1 ^ ((64'(c) * GLD) << 16);
      m_z2[c] = I2 ^ ((64'(c) * GLD) << 16);
      m_z3[c] = I3 ^ ((64'(c) * GLD) << 16);
    end
  endtask

  task automatic gen_sample(output logic [NCH*DW-1:0] v);
    logic [63:0] u, b;
    int mag;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      b = ((m_z1[c] << 1) ^ m_z1[c]) >> 53;
      m_z1[c] = ((m_z1[c] & 64'hFFFF_FFFF_FFFF_FFFE) << 10) ^ b;
      b = ((m_z2[c] << 24) ^ m_z2[c]) >> 50;
      m_z2[c] = ((m_z2[c] & 64'hFFFF_FFFF_FFFF_FE00) << 5) ^ b;
      b = ((m_z3[c] << 3) ^ m_z3[c]) >> 23;
      m_z3[c] = ((m_z3[c] & 64'hFFFF_FFFF_FFFF_F000) << 29) ^ b;
      u = m_z1[c] ^ m_z2[c] ^ m_z3[c];
      mag = 0;
      for (int i = 0; i < DEPTH; i++) if (u[62:0] >= thr[i]) mag++;
      v[c*DW +: DW] = (u[63] && mag != 0) ? DW'(-mag) : DW'(mag);
    end
  endtask

  // Apply one clock of the current inputs to the model, then compare at the falling edge.
  task automatic tick();
    logic acc, adv;
    logic [NCH*DW-1:0] s;
    acc = 1'b0;
    if (rst) begin
      sb_q.delete();
      reset_model();
      exp_err = 1'b0;
    end else begin
      if (seed_valid)
        acc = (int'(seed_ch) < NCH) && (seed_data[63:0] >= 64'd2) &&
              (seed_data[127:64] >= 64'd512) && (seed_data[191:128] >= 64'd4096);
      exp_err = seed_valid && !acc;
      adv = ce && (sb_q.size() < 3 || ready_in) && !acc;
      if (acc) begin
        sb_q.delete();
        m_z1[seed_ch] = seed_data[63:0];
        m_z2[seed_ch] = seed_data[127:64];
        m_z3[seed_ch] = seed_data[191:128];
      end else if (adv) begin
        if (sb_q.size() == 3) void'(sb_q.pop_front());
        gen_sample(s);
        sb_q.push_back(s);
      end
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (valid_out !== (sb_q.size() == 3)) begin
      n_fail++;
      $display("FAIL valid_out t=%0t: got %0b expected %0b", $time, valid_out, sb_q.size() == 3);
    end
    if (sb_q.size() == 3) begin
      n_checks++;
      if (data_out !== sb_q[0]) begin
        n_fail++;
        $display("FAIL data_out t=%0t: got %h expected %h", $time, data_out, sb_q[0]);
      end
    end
    n_checks++;
    if (seed_err !== exp_err) begin
      n_fail++;
      $display("FAIL seed_err t=%0t: got %0b expected %0b", $time, seed_err, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; ready_in = 1'b1; seed_valid = 1'b0; seed_ch = '0; seed_data = '0;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (data_out !== '0) begin
        n_fail++;
        $display("FAIL reset_data: got %h expected 0", data_out);
      end
    end
  endtask

  task automatic test_stream();
    ce = 1'b1; ready_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (valid_out !== (i == 3)) begin
        n_fail++;
        $display("FAIL latency edge %0d: got %0b expected %0b", i, valid_out, i == 3);
      end
    end
    pwr_first = sb_q[0];
    repeat (10000) tick();
  endtask

  task automatic test_backpressure();
    logic [NCH*DW-1:0] hold;
    hold = sb_q[0];
    ready_in = 1'b0;
    repeat (5) begin
      tick();
      n_checks++;
      if (data_out !== hold) begin
        n_fail++;
        $display("FAIL stall_hold: got %h expected %h", data_out, hold);
      end
    end
    ready_in = 1'b1;
    repeat (20) tick();
  endtask

  task automatic test_ce_freeze();
    ce = 1'b0;
    repeat (4) tick();
    ce = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_seed_reject();
    logic [191:0] bad [3];
    bad = '{{64'h10000, 64'd100, 64'h10000},
            {64'd4095, 64'd512, 64'd2},
            {64'd4096, 64'd512, 64'd1}};
    for (int i = 0; i < 3; i++) begin
      seed_valid = 1'b1; seed_ch = 2'(i); seed_data = bad[i];
      tick();
      n_checks++;
      if (seed_err !== 1'b1) begin
        n_fail++;
        $display("FAIL seed_reject %0d: got %0b expected 1", i, seed_err);
      end
      seed_valid = 1'b0;
      repeat (4) tick();
    end
  endtask

  task automatic test_seed_load();
    ce = 1'b0;
    seed_valid = 1'b1;
    seed_data = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F0F0F0F0F0F0F0F};
    seed_ch = 2'd0; tick();
    seed_ch = 2'd1; tick();
    seed_valid = 1'b0;
    ce = 1'b1;
    repeat (40) begin
      tick();
      if (valid_out) begin
        n_checks++;
        if (data_out[DW-1:0] !== data_out[2*DW-1:DW]) begin
          n_fail++;
          $display("FAIL lane_match: lane0 %h lane1 %h", data_out[DW-1:0], data_out[2*DW-1:DW]);
        end
      end
    end
  endtask

  task automatic test_seed_during_adv();
    seed_valid = 1'b1; seed_ch = 2'd2; seed_data = {64'd4096, 64'd512, 64'd2};
    tick();
    seed_valid = 1'b0;
    repeat (30) tick();
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (data_out !== pwr_first) begin
      n_fail++;
      $display("FAIL restart_first: got %h expected %h", data_out, pwr_first);
    end
    repeat (20) tick();
  endtask

  task automatic test_boundary();
    logic [DW-1:0] e_neg;
    e_neg = DW'(-DEPTH);
    ce = 1'b1; ready_in = 1'b1;
    force dut.g_ch[0].u_urng.r_u = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b1 || data_out[DW-1:0] !== e_neg) begin
      n_fail++;
      $display("FAIL boundary_max: got %h valid %0b expected %h", data_out[DW-1:0], valid_out, e_neg);
    end
    force dut.g_ch[0].u_urng.r_u = 64'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (data_out[DW-1:0] !== '0) begin
      n_fail++;
      $display("FAIL boundary_zero: got %h expected 0", data_out[DW-1:0]);
    end
    release dut.g_ch[0].u_urng.r_u;
  endtask

  initial begin
    init_table();
    reset_model();
    test_reset();
    test_stream();
    test_backpressure();
    test_ce_freeze();
    test_seed_reject();
    test_seed_load();
    test_seed_during_adv();
    test_reset_midstream();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gaussian_cdt_mc.md
GAUSSIAN_CDT_MC -- requirements
Module: gaussian_cdt_mc

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent sampler channels (1..16).
REQ-002 SHALL have parameter DW, default 16: signed output width per channel, two's complement.
REQ-003 SHALL have parameter CDT_DEPTH, default 16: number of cumulative-distribution table entries; CDT_DEPTH < 2^(DW-1).
REQ-004 SHALL have parameters INIT_Z1, INIT_Z2, INIT_Z3, 64-bit: base Tausworthe seeds, with defaults 5030521883283424767, 18445829279364155008 and 18436106298727503359.
REQ-005 SHALL have port clk, input, 1: single system clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port ce, input, 1: generation enable.
REQ-008 SHALL have port seed_valid, input, 1: seed load strobe.
REQ-009 SHALL have port seed_ch, input, clog2(NCH) bits (min 1): target channel of the seed load.
REQ-010 SHALL have port seed_data, input, 192: the values {z3, z2, z1}, 64 bits each.
REQ-011 SHALL have port seed_err, output, 1: one-cycle pulse indicating a rejected seed.
REQ-012 SHALL have port valid_out, output, 1: data_out holds one sample per channel.
REQ-013 SHALL have port ready_in, input, 1: consumer accepts data_out.
REQ-014 SHALL have port data_out, output, NCH*DW: channel c occupies bits [c*DW +: DW].

Function
REQ-015 Each channel SHALL contain a three-component 64-bit combined Tausworthe URNG.
- Per component: b = ((z<<q)^z)>>s; z' = ((z & m)<<r) ^ b.
- Components: (q,s,r) = (1,53,10), (24,50,5), (3,23,29); masks m = ~1, ~511, ~4095.
- Output: u = z1^z2^z3.
REQ-016 Reset state of channel c SHALL be INIT_Zk ^ ((c*64'h9E3779B97F4A7C15) << 16) for k = 1..3.
REQ-017 The pipeline SHALL have three stages: S1 registers u; S2 computes sign = u[63] and mag = count of i with u[62:0] >= CDT_TABLE[i]; S3 registers the signed result.
REQ-018 The S3 result SHALL be -mag when sign = 1 and mag != 0, otherwise +mag; zero is never negated.
REQ-019 The mag comparison SHALL evaluate all CDT_DEPTH entries every cycle, with no early exit, so that it runs in constant time.
REQ-020 The pipeline SHALL advance (adv) when ce=1 and (valid_out=0 or ready_in=1); all channels step in lockstep.
REQ-021 URNG state SHALL update only on adv, so that the sample sequence is independent of backpressure.
REQ-022 Latency SHALL be 3 cycles: on an idle pipeline, the first ce=1 cycle gives valid_out=1 three edges later.
REQ-023 While valid_out=1 and ready_in=0, data_out and valid_out SHALL hold stable.
REQ-024 ce=0 SHALL freeze all state, and an already-asserted valid_out SHALL stay asserted.
REQ-025 A seed SHALL be rejected, with seed_err=1 on the next cycle and no state change, if z1<2, z2<512 or z3<4096.
REQ-026 An accepted seed SHALL replace channel seed_ch's state on the next edge and clear all in-flight valid bits.
- valid_out goes to 0 on the next cycle.
- Refill latency restarts at 3.
REQ-027 A seed_ch >= NCH SHALL be rejected as in REQ-025.
REQ-028 When seed_valid and adv occur in the same cycle, the seed SHALL win: no URNG step for that channel and pipeline flushed per REQ-026.
REQ-029 seed_valid SHALL take effect regardless of ce.

Reset
REQ-030 On rst=1, the URNG states SHALL be set per REQ-016 and valid_out, seed_err and data_out SHALL be cleared to 0.
REQ-031 Reset asserted mid-stream SHALL discard in-flight samples; after release, the output sequence SHALL restart identically to that after power-on reset.

Structure
REQ-032 A shared package gaussian_pkg SHALL hold:
- CDT_TABLE: array of 63-bit thresholds, strictly increasing, sigma = 3.19 set, CDT_DEPTH entries.
- Tausworthe shift/mask constants.
- Minimum-seed constants.
- The golden-ratio channel offset.
REQ-033 There SHALL be one sub-module, taus_urng: per-channel state plus step, with load/advance inputs, instantiated NCH times via generate.

Verification
REQ-034 Reset behaviour: rst=1 for 2 cycles, then rst=0 and ce=0 -> valid_out=0, data_out=0, seed_err=0 indefinitely.
REQ-035 Latency and sequence: ce=1 and ready_in=1 from cycle 0 -> valid_out=1 at cycle 3; channel 0 sequence matches the golden model of REQ-015/017 for 10000 samples.
REQ-036 Backpressure: ready_in=0 for 5 cycles at sample n -> data_out is constant; after release, samples n, n+1, ... match the unstalled run exactly.
REQ-037 Seed rejection: seed_data = {64'h10000, 64'd100, 64'h10000} -> seed_err=1 for one cycle, and the output stream is unchanged versus a run without the load.
REQ-038 Seed load: load channels 0 and 1 with identical valid seeds -> valid_out=0 for 3 cycles, then lane 0 == lane 1 on every sample.
REQ-039 Boundary values: force S1 u = 64'hFFFF_FFFF_FFFF_FFFF -> lane output = -CDT_DEPTH (-16); force u = 0 -> output 0.
